// File: rtl/init_pkg.sv
// init_pkg: shared widths, the last fill address and the fill FSM state type.
package init_pkg;
   localparam int ADDR_W_DEFAULT = 8;
   localparam int LAST_ADDR = 255;
   typedef enum logic [1:0] {IDLE, ARM, SETUP, WRITE} init_state_t;
endpackage

// File: rtl/init_ctr.sv
// init_ctr: up-counter with clear, increment enable and a terminal-count flag.
module init_ctr
   import init_pkg::*;
#(
   parameter int W    = ADDR_W_DEFAULT,
   parameter int LAST = LAST_ADDR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n)      r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + 1'b1;
   assign o_cnt = r_cnt;
   assign o_tc  = r_cnt == W'(LAST);
endmodule

// File: rtl/init.sv
// init: fills the S-array RAM with S[i]=i, one write per clock, on an en/rdy request.
// Optional macro INIT_DONE_PULSE_EN adds a one-cycle done pulse as rdy returns.
module init
   import init_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] wrdata,
   output logic              wren
`ifdef INIT_DONE_PULSE_EN
   ,
   output logic              done
`endif
);
   init_state_t       r_state, w_next;
   logic              r_rdy, r_wren;
   logic [ADDR_W-1:0] w_cnt;
   logic              w_tc;
   // Clear wins over increment, so the counter returns to 0 instead of wrapping.
   init_ctr #(.W(ADDR_W), .LAST((1 << ADDR_W) - 1)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (r_state != WRITE || w_tc),
      .i_inc (r_state == WRITE),
      .o_cnt (w_cnt),
      .o_tc  (w_tc)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = en ? ARM : IDLE;
         ARM:     w_next = SETUP;
         SETUP:   w_next = WRITE;
         WRITE:   w_next = w_tc ? IDLE : WRITE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         r_state <= IDLE;
         r_rdy   <= 1'b1;
         r_wren  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_rdy   <= w_next == IDLE;
         r_wren  <= w_next == WRITE;
      end
   assign rdy    = r_rdy;
   assign wren   = r_wren;
   assign addr   = w_cnt;
   assign wrdata = w_cnt;
`ifdef INIT_DONE_PULSE_EN
   logic r_done;
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) r_done <= 1'b0;
      else       r_done <= r_state == WRITE && w_tc;
   assign done = r_done;
`endif
endmodule

// File: tb/tb_init.sv
// tb_init: randomized scoreboard bench for init against a queue-based fill model.
module tb_init;
   typedef struct {
      int cyc;
      int a;
   } wr_t;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic [7:0] addr;
   logic [7:0] wrdata;
   logic       wren;
`ifdef INIT_DONE_PULSE_EN
   logic       done;
`endif
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  busy_end = 0;
   int  done_edge = -1;
   wr_t q[$];
   init dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .rdy    (rdy),
      .addr   (addr),
      .wrdata (wrdata),
      .wren   (wren)
`ifdef INIT_DONE_PULSE_EN
      ,
      .done   (done)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask
   // Reference model: an accepted request schedules 256 writes at edges k+2..k+257.
   always @(posedge rst_n) begin
      q.delete();
      busy_end  = 0;
      done_edge = -1;
   end
   always @(posedge clk) begin
      cyc++;
      if (!rst_n && en && cyc - 1 >= busy_end) begin
         for (int n = 0; n < 256; n++) q.push_back('{cyc + 2 + n, n});
         busy_end  = cyc + 258;
         done_edge = cyc + 258;
      end
   end
   always @(negedge clk) begin
      bit exp_w;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      exp_w = q.size() > 0 && q[0].cyc == cyc;
      check("rdy", int'(rdy), int'(cyc >= busy_end));
      check("wren", int'(wren), int'(exp_w));
`ifdef INIT_DONE_PULSE_EN
      check("done", int'(done), int'(cyc == done_edge));
`endif
      if (exp_w) begin
         check("addr", int'(addr), q[0].a);
         check("wrdata", int'(wrdata), q[0].a);
         void'(q.pop_front());
      end else begin
         check("addr_idle", int'(addr), 0);
         check("wrdata_idle", int'(wrdata), 0);
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask
   initial begin
      int t;
      rst_n = 1'b1;
      en    = 1'b0;
      tick(2);
      rst_n = 1'b0;
      tick(3);
      en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(270);
      en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(4);
      en = 1'b1;
      tick(95);
      en = 1'b0;
      tick(200);
      en = 1'b1;
      tick(600);
      en = 1'b0;
      tick(300);
      en = 1'b1;
      tick(1);
      en = 1'b0;
      t = 0;
      while (!(wren && addr == 8'd100) && t < 400) begin
         tick(1);
         t++;
      end
      check("reach_addr100", int'(t < 400), 1);
      rst_n = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick(2);
      en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(270);
      for (int i = 0; i < 40; i++) begin
         en = ($urandom % 4) == 0;
         tick($urandom_range(1, 120));
      end
      en = 1'b0;
      tick(300);
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
